// File: rtl/instr_fetch_unit.sv
// Fetch stage with IF/ID register: PC, req/rdy imem handshake, one-entry skid, branch flush.
// One instruction per cycle with zero-wait memory; a stall parks one response in the skid buffer and stops requesting.
module instr_fetch_unit #(
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_rdy,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic [6:0]      opcode,
  output logic [PC_W-1:0] pc_out,
  output logic            instr_valid
);

  typedef enum logic [1:0] {START, FETCH, SKID} state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc;
  logic            drop;
  logic [PC_W-1:0] drop_addr;
  logic [31:0]     skid_instr;
  logic [PC_W-1:0] skid_pc;
  logic            accept;
  logic            outstanding;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= START;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    imem_addr   = pc;
    accept      = 1'b0;
    outstanding = 1'b0;
    case (state)
      START: state_nxt = FETCH;
      FETCH: begin
        imem_req    = 1'b1;
        // The address of an abandoned fetch must stay put until memory answers it.
        if (drop) imem_addr = drop_addr;
        accept      = imem_rdy && !drop;
        outstanding = !imem_rdy;
        if (accept && stall && instr_valid) state_nxt = SKID;
      end
      SKID: if (!stall) state_nxt = FETCH;
      default: state_nxt = START;
    endcase
    if (branch_taken) state_nxt = FETCH;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      drop        <= 1'b0;
      drop_addr   <= RESET_PC;
      skid_instr  <= NOP_INSTR;
      skid_pc     <= '0;
      instr       <= NOP_INSTR;
      pc_out      <= '0;
      instr_valid <= 1'b0;
    end else if (branch_taken) begin
      pc          <= {branch_target[PC_W-1:2], 2'b00};
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
      skid_instr  <= NOP_INSTR;
      // A response in the branch cycle is simply discarded; only a still-pending one must be swallowed later.
      drop        <= outstanding;
      if (outstanding && !drop) drop_addr <= pc;
    end else begin
      case (state)
        FETCH: begin
          if (drop && imem_rdy) drop <= 1'b0;
          if (accept) begin
            pc <= pc + PC_W'(4);
            if (!stall || !instr_valid) begin
              instr       <= imem_rdata;
              pc_out      <= pc;
              instr_valid <= 1'b1;
            end else begin
              skid_instr <= imem_rdata;
              skid_pc    <= pc;
            end
          end else if (!stall) begin
            instr       <= NOP_INSTR;
            instr_valid <= 1'b0;
          end
        end
        SKID: begin
          if (!stall) begin
            instr       <= skid_instr;
            pc_out      <= skid_pc;
            instr_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign opcode = instr[6:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a 32-bit instance behind a latency-programmable memory
// returning its address as data, plus an 8-bit instance for PC wrap and asynchronous reset.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall, branch_taken;
  logic [31:0] branch_target;
  logic        imem_req, imem_rdy;
  logic [31:0] imem_addr, imem_rdata, instr, pc_out;
  logic [6:0]  opcode;
  logic        instr_valid;
  int          lat;
  int          wait_cnt;

  logic        reset2, stall2, branch2, req2, rdy2, en2, valid2;
  logic [7:0]  target2, addr2, pc_out2;
  logic [31:0] rdata2, instr2;
  logic [6:0]  opcode2;

  int checks = 0;
  int failures = 0;

  instr_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdy(imem_rdy), .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode),
    .pc_out(pc_out), .instr_valid(instr_valid)
  );

  instr_fetch_unit #(.PC_W(8), .RESET_PC(8'hF8)) dut8 (
    .clk(clk), .reset(reset2), .stall(stall2), .branch_taken(branch2),
    .branch_target(target2), .imem_req(req2), .imem_addr(addr2),
    .imem_rdy(rdy2), .imem_rdata(rdata2), .instr(instr2), .opcode(opcode2),
    .pc_out(pc_out2), .instr_valid(valid2)
  );

  // Memory answers once a request has waited lat cycles; lat=0 is zero-wait.
  assign imem_rdy   = imem_req && (wait_cnt >= lat);
  assign imem_rdata = imem_addr;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     wait_cnt <= 0;
    else if (imem_req && !imem_rdy) wait_cnt <= wait_cnt + 1;
    else                           wait_cnt <= 0;
  end

  assign rdy2   = req2 & en2;
  assign rdata2 = {24'h0, addr2};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0; lat = 0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0; lat = 0;
    step();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0b exp=0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
    checks++; if (instr !== 32'h13) begin failures++; $display("FAIL reset_instr got=%h exp=13", instr); end
    checks++; if (opcode !== 7'h13) begin failures++; $display("FAIL reset_opcode got=%h exp=13", opcode); end
    checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL reset_pc_out got=%h exp=0", pc_out); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", instr_valid); end
    reset = 1'b0;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL start_req got=%0b exp=0", imem_req); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] e;
    apply_reset();
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
      failures++; $display("FAIL zw_first_req req=%0b addr=%h valid=%0b exp 1/0/0", imem_req, imem_addr, instr_valid); end
    for (int i = 0; i < 4; i++) begin
      step();
      e = 32'(i * 4);
      checks++; if (instr_valid !== 1'b1 || pc_out !== e || opcode !== e[6:0]) begin
        failures++; $display("FAIL zw_stream%0d valid=%0b pc=%h op=%h exp pc=%h", i, instr_valid, pc_out, opcode, e); end
    end
  endtask

  task automatic test_delay();
    apply_reset();
    lat = 3;
    step();
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1 || instr_valid !== 1'b0 || instr !== 32'h13) begin
        failures++; $display("FAIL delay_wait%0d addr=%h req=%0b valid=%0b instr=%h", i, imem_addr, imem_req, instr_valid, instr); end
      step();
    end
    step();
    checks++; if (instr_valid !== 1'b1 || pc_out !== 32'h0 || instr !== 32'h0 || imem_addr !== 32'h4) begin
      failures++; $display("FAIL delay_capture valid=%0b pc=%h instr=%h addr=%h exp 1/0/0/4", instr_valid, pc_out, instr, imem_addr); end
    lat = 0;
  endtask

  task automatic test_stall();
    apply_reset();
    step(); step(); step();
    checks++; if (pc_out !== 32'h4) begin failures++; $display("FAIL stall_pre got=%h exp=4", pc_out); end
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (pc_out !== 32'h4 || instr_valid !== 1'b1 || imem_req !== 1'b0) begin
        failures++; $display("FAIL stall_hold%0d pc=%h valid=%0b req=%0b exp 4/1/0", i, pc_out, instr_valid, imem_req); end
    end
    stall = 1'b0;
    step();
    checks++; if (pc_out !== 32'h8 || instr !== 32'h8 || imem_req !== 1'b1 || imem_addr !== 32'hC) begin
      failures++; $display("FAIL stall_release pc=%h instr=%h req=%0b addr=%h", pc_out, instr, imem_req, imem_addr); end
    step();
    checks++; if (pc_out !== 32'hC || instr_valid !== 1'b1) begin
      failures++; $display("FAIL stall_next pc=%h valid=%0b exp C/1", pc_out, instr_valid); end
  endtask

  task automatic test_branch_skid();
    apply_reset();
    step(); step(); step();
    stall = 1'b1;
    step();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bskid_in_skid req=%0b exp=0", imem_req); end
    branch_taken = 1'b1; branch_target = 32'h103;
    step();
    branch_taken = 1'b0; stall = 1'b0;
    checks++; if (instr_valid !== 1'b0 || instr !== 32'h13 || opcode !== 7'h13 || imem_addr !== 32'h100 || imem_req !== 1'b1) begin
      failures++; $display("FAIL bskid_flush valid=%0b instr=%h addr=%h req=%0b", instr_valid, instr, imem_addr, imem_req); end
    step();
    checks++; if (instr_valid !== 1'b1 || pc_out !== 32'h100 || instr !== 32'h100) begin
      failures++; $display("FAIL bskid_target valid=%0b pc=%h instr=%h exp 1/100/100", instr_valid, pc_out, instr); end
    step();
    checks++; if (pc_out !== 32'h104) begin failures++; $display("FAIL bskid_follow got=%h exp=104", pc_out); end
  endtask

  task automatic test_branch_outstanding();
    apply_reset();
    for (int i = 0; i < 5; i++) step();
    checks++; if (imem_addr !== 32'h10) begin failures++; $display("FAIL bout_setup addr=%h exp=10", imem_addr); end
    lat = 2; branch_taken = 1'b1; branch_target = 32'h200;
    step();
    branch_taken = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (instr_valid !== 1'b0 || imem_addr !== 32'h10 || imem_req !== 1'b1) begin
        failures++; $display("FAIL bout_hold%0d valid=%0b addr=%h req=%0b exp 0/10/1", i, instr_valid, imem_addr, imem_req); end
      step();
    end
    checks++; if (instr_valid !== 1'b0 || imem_addr !== 32'h200) begin
      failures++; $display("FAIL bout_discard valid=%0b pc=%h addr=%h exp valid 0 addr 200", instr_valid, pc_out, imem_addr); end
    lat = 0;
    step();
    checks++; if (instr_valid !== 1'b1 || pc_out !== 32'h200) begin
      failures++; $display("FAIL bout_target valid=%0b pc=%h exp 1/200", instr_valid, pc_out); end
  endtask

  task automatic test_wrap_async_reset();
    logic [7:0] e;
    reset2 = 1'b1; en2 = 1'b1;
    step();
    reset2 = 1'b0;
    step();
    checks++; if (req2 !== 1'b1 || addr2 !== 8'hF8) begin failures++; $display("FAIL wrap_first req=%0b addr=%h exp 1/F8", req2, addr2); end
    for (int i = 0; i < 4; i++) begin
      step();
      e = 8'hF8 + 8'(4 * i);
      checks++; if (pc_out2 !== e || valid2 !== 1'b1) begin
        failures++; $display("FAIL wrap_pc%0d got=%h valid=%0b exp=%h", i, pc_out2, valid2, e); end
    end
    en2 = 1'b0;
    step();
    checks++; if (req2 !== 1'b1) begin failures++; $display("FAIL wrap_pending req=%0b exp=1", req2); end
    #2;
    reset2 = 1'b1;
    #1;
    checks++; if (req2 !== 1'b0 || valid2 !== 1'b0 || instr2 !== 32'h13 || opcode2 !== 7'h13 || pc_out2 !== 8'h0 || addr2 !== 8'hF8) begin
      failures++; $display("FAIL async_reset req=%0b valid=%0b instr=%h pc=%h addr=%h", req2, valid2, instr2, pc_out2, addr2); end
    en2 = 1'b1;
    step();
    checks++; if (valid2 !== 1'b0) begin failures++; $display("FAIL async_no_capture valid=%0b exp=0", valid2); end
    reset2 = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0; lat = 0;
    reset2 = 1'b1; stall2 = 1'b0; branch2 = 1'b0; target2 = '0; en2 = 1'b1;
    test_reset();
    test_zero_wait();
    test_delay();
    test_stall();
    test_branch_skid();
    test_branch_outstanding();
    test_wrap_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
